// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2-read/1-write register file.
// The default build has no write-to-read forwarding; define REGFILE_BYPASS_EN to enable it.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Address width never drops below one bit, even for tiny depths
    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_cell.sv
// One register-file entry: async reset, synchronous clear, load enable.
// Clear takes priority over load.
module regfile_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with a sequential clear engine and a dropped-write flag.
// Define REGFILE_BYPASS_EN to forward an accepted write onto matching read ports before the edge.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    input  logic             oeA,
    input  logic             oeB,
    output logic [WIDTH-1:0] DA,
    output logic [WIDTH-1:0] DB,
    input  logic             clr_start,
    output logic             busy,
    output logic             wr_err
);

    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    clr_cnt;
    logic [WIDTH-1:0] q [DEPTH];
    logic             wr_in_range;
    logic             wr_ok;
    logic             wr_drop;
    logic [WIDTH-1:0] rd_a, rd_b;

    // A write only lands when idle, in range, and not pre-empted by a clear request
    assign wr_in_range = ({1'b0, waddr} < DEPTH_LIM);
    assign wr_ok       = we && (state == IDLE) && !clr_start && wr_in_range;
    assign wr_drop     = we && !wr_ok;
    assign busy        = (state == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
            wr_err  <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_err <= wr_drop;
            if (state == IDLE || clr_cnt == LAST)
                clr_cnt <= '0;
            else
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        regfile_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (wr_ok && (waddr == AW'(i))),
            .clear (busy && (clr_cnt == AW'(i))),
            .d     (wdata),
            .q     (q[i])
        );
    end

    // Out-of-range reads return zero rather than an undefined entry
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if ({1'b0, ra_addr} < DEPTH_LIM)
            rd_a = q[ra_addr];
        if ({1'b0, rb_addr} < DEPTH_LIM)
            rd_b = q[rb_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (waddr == ra_addr))
            rd_a = wdata;
        if (wr_ok && (waddr == rb_addr))
            rd_b = wdata;
`endif
    end

    assign DA = oeA ? rd_a : {WIDTH{1'bz}};
    assign DB = oeB ? rd_b : {WIDTH{1'bz}};

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: a DEPTH=8 instance plus a DEPTH=6 instance sharing inputs.
// Expected values are pushed by the stimulus thread; a monitor thread pops and compares them.
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int K_DA = 0, K_DB = 1, K_BUSY = 2, K_WRERR = 3, K_DA6 = 4, K_DB6 = 5, K_WRERR6 = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra_addr, rb_addr;
    logic        oeA, oeB;
    logic        clr_start;
    wire  [15:0] DA, DB, DA6, DB6;
    wire         busy, wr_err, busy6, wr_err6;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp;
        bit          expZ;
    } exp_t;

    exp_t q[$];
    int   pendingCnt = 0;
    int   vectorsApplied = 0;
    int   miscompares = 0;
    event sampleEv;

    regfile_2r1w #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .oeA(oeA), .oeB(oeB),
        .DA(DA), .DB(DB), .clr_start(clr_start), .busy(busy), .wr_err(wr_err)
    );

    regfile_2r1w #(.WIDTH(16), .DEPTH(6)) dut6 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .oeA(oeA), .oeB(oeB),
        .DA(DA6), .DB(DB6), .clr_start(clr_start), .busy(busy6), .wr_err(wr_err6)
    );

    always #5 clk = ~clk;

    // Monitor: drains every queued expectation each time the stimulus flags a sample point
    initial begin
        exp_t        e;
        logic [15:0] act;
        bit          ok;
        forever begin
            @(sampleEv);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = 16'h0;
                ok  = 1'b0;
                case (e.kind)
                    K_DA:     act = DA;
                    K_DB:     act = DB;
                    K_BUSY:   act = {15'h0, busy};
                    K_WRERR:  act = {15'h0, wr_err};
                    K_DA6:    act = DA6;
                    K_DB6:    act = DB6;
                    K_WRERR6: act = {15'h0, wr_err6};
                    default:  act = 16'h0;
                endcase
                if (e.expZ)
                    ok = (e.kind == K_DA) ? (DA === 16'hzzzz) : (DB === 16'hzzzz);
                else
                    ok = (act === e.exp);
                vectorsApplied++;
                if (!ok) begin
                    miscompares++;
                    if (e.expZ)
                        $display("[TB] FAIL %s: got %h, expected zzzz", e.name, act);
                    else
                        $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
                pendingCnt--;
            end
        end
    end

    task automatic pushExp(input int kind, input logic [15:0] exp, input bit expZ, input string name);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        e.expZ = expZ;
        q.push_back(e);
        pendingCnt++;
        -> sampleEv;
        wait (pendingCnt == 0);
    endtask

    task automatic checkOutput(input int kind, input logic [15:0] exp, input string name);
        pushExp(kind, exp, 1'b0, name);
    endtask

    task automatic checkZ(input int kind, input string name);
        pushExp(kind, 16'h0, 1'b1, name);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic iwe, input logic [2:0] iwa, input logic [15:0] iwd,
                                 input logic iclr, input logic [2:0] ira, input logic [2:0] irb);
        we        = iwe;
        waddr     = iwa;
        wdata     = iwd;
        clr_start = iclr;
        ra_addr   = ira;
        rb_addr   = irb;
        #1;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            vectorsApplied++;
            miscompares++;
            $display("[TB] FAIL busy_timeout: got %b, expected 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        oeA = 1'b1;
        oeB = 1'b1;
        applyStimulus(0, 0, 16'h0, 0, 0, 0);
        #2;
        checkOutput(K_DA, 16'h0000, "reset_DA");
        checkOutput(K_BUSY, 16'h0, "reset_busy");
        checkOutput(K_WRERR, 16'h0, "reset_wr_err");
        tick();
        reset = 1'b0;
        #1;

        // Basic write, readback, and tri-state
        applyStimulus(1, 3, 16'hBEEF, 0, 3, 3);
        tick();
        applyStimulus(0, 0, 16'h0, 0, 3, 3);
        checkOutput(K_DA, 16'hBEEF, "write3_DA");
        checkOutput(K_WRERR, 16'h0, "write3_no_err");
        oeA = 1'b0;
        #1;
        checkZ(K_DA, "oeA_low_Z");
        oeA = 1'b1;
        #1;

        // Forwarding behaviour before and after the write edge
        applyStimulus(1, 5, 16'h5555, 0, 5, 5);
        tick();
        applyStimulus(1, 5, 16'h1234, 0, 5, 5);
        checkOutput(K_DA, BYPASS ? 16'h1234 : 16'h5555, "pre_edge_DA");
        checkOutput(K_DB, BYPASS ? 16'h1234 : 16'h5555, "pre_edge_DB");
        tick();
        applyStimulus(0, 0, 16'h0, 0, 5, 5);
        checkOutput(K_DA, 16'h1234, "post_edge_DA");

        // Fill, then clear; a clr_start mid-sequence must not extend it
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 3'(i), 16'hA000 | 16'(i), 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 16'h0, 1, 7, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 16'h0, (k == 2), 7, 0);
            checkOutput(K_BUSY, 16'h1, $sformatf("clear_busy_c%0d", k + 1));
            checkOutput(K_DA, 16'hA007, $sformatf("clear_DA7_c%0d", k + 1));
            checkOutput(K_DB, (k == 0) ? 16'hA000 : 16'h0000, $sformatf("clear_DB0_c%0d", k + 1));
            tick();
        end
        checkOutput(K_BUSY, 16'h0, "clear_done_busy");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 16'h0, 0, 3'(i), 3'(7 - i));
            checkOutput(K_DA, 16'h0000, $sformatf("cleared_DA%0d", i));
        end

        // Write during CLEAR is dropped
        applyStimulus(1, 2, 16'h2222, 0, 2, 2);
        tick();
        applyStimulus(0, 0, 16'h0, 1, 2, 2);
        tick();
        applyStimulus(1, 2, 16'hFFFF, 0, 2, 2);
        tick();
        applyStimulus(0, 0, 16'h0, 0, 2, 2);
        checkOutput(K_WRERR, 16'h1, "busy_write_err");
        checkOutput(K_DA, 16'h2222, "busy_write_entry");
        tick();
        checkOutput(K_WRERR, 16'h0, "busy_write_err_end");
        checkOutput(K_DA, 16'h2222, "busy_write_entry2");
        waitIdle();
        checkOutput(K_DA, 16'h0000, "busy_write_cleared");

        // Write and clr_start on the same edge: clear wins
        applyStimulus(1, 4, 16'h4444, 0, 4, 4);
        tick();
        applyStimulus(1, 4, 16'hFFFF, 1, 4, 4);
        tick();
        applyStimulus(0, 0, 16'h0, 0, 4, 4);
        checkOutput(K_WRERR, 16'h1, "same_edge_err");
        checkOutput(K_BUSY, 16'h1, "same_edge_busy");
        checkOutput(K_DA, 16'h4444, "same_edge_entry");
        tick();
        checkOutput(K_WRERR, 16'h0, "same_edge_err_end");
        waitIdle();

        // Reset in the middle of a clear
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 3'(i), 16'h3000 | 16'(i), 0, 5, 7);
            tick();
        end
        applyStimulus(0, 0, 16'h0, 1, 5, 7);
        tick();
        applyStimulus(0, 0, 16'h0, 0, 5, 7);
        tick();
        tick();
        reset = 1'b1;
        #1;
        checkOutput(K_BUSY, 16'h0, "mid_reset_busy");
        checkOutput(K_WRERR, 16'h0, "mid_reset_wr_err");
        checkOutput(K_DA, 16'h0000, "mid_reset_DA5");
        checkOutput(K_DB, 16'h0000, "mid_reset_DB7");
        oeB = 1'b0;
        #1;
        checkZ(K_DB, "mid_reset_DB_Z");
        oeB = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        applyStimulus(1, 0, 16'h0A0A, 0, 0, 7);
        tick();
        applyStimulus(1, 7, 16'h7777, 0, 0, 7);
        tick();
        applyStimulus(0, 0, 16'h0, 1, 0, 7);
        tick();
        applyStimulus(0, 0, 16'h0, 0, 0, 7);
        tick();
        checkOutput(K_DA, 16'h0000, "restart_DA0");
        checkOutput(K_DB, 16'h7777, "restart_DB7");
        checkOutput(K_BUSY, 16'h1, "restart_busy");
        waitIdle();

        // DEPTH=6 instance: out-of-range write and read
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        applyStimulus(1, 5, 16'h5A5A, 0, 5, 7);
        tick();
        applyStimulus(1, 7, 16'hDEAD, 0, 5, 7);
        tick();
        applyStimulus(0, 0, 16'h0, 0, 5, 7);
        checkOutput(K_WRERR6, 16'h1, "d6_oor_err");
        checkOutput(K_WRERR, 16'h0, "d8_addr7_no_err");
        checkOutput(K_DA6, 16'h5A5A, "d6_entry5");
        checkOutput(K_DB6, 16'h0000, "d6_read7");
        tick();
        checkOutput(K_WRERR6, 16'h0, "d6_oor_err_end");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 16'h0, 0, 3'(i), 6);
            checkOutput(K_DA6, 16'h0000, $sformatf("d6_entry%0d", i));
        end
        checkOutput(K_DB6, 16'h0000, "d6_read6");

        wait (pendingCnt == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
